// File: rtl/irrig_pkg.sv
// Shared types and constants for the multi-zone irrigation controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, tank-level and zone-mode constants, and to_bcd(),
// which converts a 0..99 parameter into a {tens, units} BCD byte for timer loads.
package irrig_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IRRIGATE = 2'd1,
      MIX      = 2'd2,
      CLEAN    = 2'd3
   } state_e;

   localparam logic [1:0] NV_EMPTY = 2'b00;
   localparam logic [1:0] NV_LOW   = 2'b01;

   localparam logic MODE_SPRINKLE = 1'b1;
   localparam logic MODE_DRIP     = 1'b0;

   function automatic logic [7:0] to_bcd(input int unsigned v);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = 4'(v / 10);
      units = 4'(v % 10);
      return {tens, units};
   endfunction

endpackage

// File: rtl/bcd_down_timer.sv
// Two-digit BCD seconds countdown with its own 1 s prescaler.
// Latency: load takes effect on the next Clk edge; first decrement TICK_DIV cycles later.
// Backpressure: none; load always wins over a coincident tick.
// Ports: Clk, Rst (async active-low), load_i/load_val_i (restart with a BCD value and
// clear the prescaler), bcd_o (registered count), zero_o (count is 00), tick_o (1 s pulse).
module bcd_down_timer #(
   parameter int TICK_DIV = 4
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   output logic [7:0] bcd_o,
   output logic       zero_o,
   output logic       tick_o
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]    bcd_q, bcd_d;

   assign tick_o = (pre_q == PW'(TICK_DIV - 1));
   assign zero_o = (bcd_q == 8'h00);
   assign bcd_o  = bcd_q;

   always_comb begin
      pre_d = tick_o ? '0 : pre_q + PW'(1);
      bcd_d = bcd_q;
      // Count holds at 00; a units borrow reloads 9 and takes one from tens,
      // so no non-BCD nibble is ever produced.
      if (tick_o && !zero_o) begin
         if (bcd_q[3:0] == 4'd0) bcd_d = {bcd_q[7:4] - 4'd1, 4'd9};
         else                    bcd_d = {bcd_q[7:4], bcd_q[3:0] - 4'd1};
      end
      if (load_i) begin
         pre_d = '0;
         bcd_d = load_val_i;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pre_q <= '0;
         bcd_q <= 8'h00;
      end else begin
         pre_q <= pre_d;
         bcd_q <= bcd_d;
      end
   end

endmodule

// File: rtl/irrig_zone_ctrl.sv
// Multi-zone irrigation scheduler with fertilizer mix and line-cleaning sequence.
// Latency: request seen in IDLE drives valve/pump on the next Clk edge; all outputs registered.
// Backpressure: none; requests are levels, re-evaluated every IDLE cycle.
// Ports: Us (dry request per zone), Mode (1 sprinkler / 0 drip), Nv (tank level), Adub
// (fertilize request) in; Valve (one-hot), Asp/Got (pumps), Mist/Limp (mix/clean),
// Zone_idx (active or last zone), Time_bcd (BCD seconds left), Alarm (tank empty) out.
// Build option IRRIG_FIXED_PRIORITY_EN: lowest eligible zone wins instead of round-robin.
module irrig_zone_ctrl
   import irrig_pkg::*;
#(
   parameter int NUM_ZONES     = 4,
   parameter int TICK_DIV      = 50000000,
   parameter int SPRINKLE_TIME = 15,
   parameter int DRIP_TIME     = 30,
   parameter int MIX_TIME      = 5,
   parameter int CLEAN_TIME    = 10
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [NUM_ZONES-1:0]         Us,
   input  logic [NUM_ZONES-1:0]         Mode,
   input  logic [1:0]                   Nv,
   input  logic                         Adub,
   output logic [NUM_ZONES-1:0]         Valve,
   output logic                         Asp,
   output logic                         Got,
   output logic                         Mist,
   output logic                         Limp,
   output logic [$clog2(NUM_ZONES)-1:0] Zone_idx,
   output logic [7:0]                   Time_bcd,
   output logic                         Alarm
);

   localparam int ZW = $clog2(NUM_ZONES);

   localparam logic [7:0] SPR_BCD   = to_bcd(SPRINKLE_TIME);
   localparam logic [7:0] DRIP_BCD  = to_bcd(DRIP_TIME);
   localparam logic [7:0] MIX_BCD   = to_bcd(MIX_TIME);
   localparam logic [7:0] CLEAN_BCD = to_bcd(CLEAN_TIME);

   if (NUM_ZONES < 2 || NUM_ZONES > 8) begin : g_bad_zones
      $error("irrig_zone_ctrl: NUM_ZONES must be 2..8");
   end
   if (SPRINKLE_TIME < 1 || SPRINKLE_TIME > 99 || DRIP_TIME < 1 || DRIP_TIME > 99 ||
       MIX_TIME < 1 || MIX_TIME > 99 || CLEAN_TIME < 1 || CLEAN_TIME > 99) begin : g_bad_time
      $error("irrig_zone_ctrl: time parameters must be 1..99");
   end
   if (TICK_DIV < 1) begin : g_bad_div
      $error("irrig_zone_ctrl: TICK_DIV must be >= 1");
   end

   state_e                 state_q, state_d;
   logic [NUM_ZONES-1:0]   valve_q;
   logic                   asp_q, got_q, mist_q, limp_q, alarm_q, fert_pend_q;
   logic [ZW-1:0]          zone_q;

   logic [NUM_ZONES-1:0]   elig;
   logic [ZW-1:0]          sel;
   logic                   load;
   logic [7:0]             load_val;
   logic                   tick, zero;
   logic [7:0]             bcd;

   // Low tank only feeds drip zones; empty tank feeds nothing.
   always_comb begin
      for (int i = 0; i < NUM_ZONES; i++) begin
         elig[i] = Us[i] && (Nv != NV_EMPTY) && ((Nv != NV_LOW) || (Mode[i] == MODE_DRIP));
      end
   end

`ifdef IRRIG_FIXED_PRIORITY_EN
   always_comb begin
      sel = '0;
      for (int i = NUM_ZONES - 1; i >= 0; i--) begin
         if (elig[ZW'(i)]) sel = ZW'(i);
      end
   end
`else
   // rr_q is the last zone granted (including aborted runs); search starts one past it.
   logic [ZW-1:0] rr_q;
   logic          found;
   int            idx;

   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_ZONES; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_ZONES) idx = idx - NUM_ZONES;
         if (!found && elig[ZW'(idx)]) begin
            sel   = ZW'(idx);
            found = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (fert_pend_q || Adub) state_d = MIX;
            else if (|elig)          state_d = IRRIGATE;
         end
         IRRIGATE: if ((Nv == NV_EMPTY) || (tick && zero)) state_d = IDLE;
         MIX:      if (tick && zero) state_d = CLEAN;
         CLEAN:    if (tick && zero) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Every state change reloads the timer; IDLE loads 00 so an aborted run
   // does not leave a stale count on the display.
   always_comb begin
      load = (state_d != state_q);
      unique case (state_d)
         IRRIGATE: load_val = (Mode[sel] == MODE_SPRINKLE) ? SPR_BCD : DRIP_BCD;
         MIX:      load_val = MIX_BCD;
         CLEAN:    load_val = CLEAN_BCD;
         default:  load_val = 8'h00;
      endcase
   end

   bcd_down_timer #(.TICK_DIV(TICK_DIV)) u_timer (
      .Clk        (Clk),
      .Rst        (Rst),
      .load_i     (load),
      .load_val_i (load_val),
      .bcd_o      (bcd),
      .zero_o     (zero),
      .tick_o     (tick)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= IDLE;
         valve_q     <= '0;
         asp_q       <= 1'b0;
         got_q       <= 1'b0;
         mist_q      <= 1'b0;
         limp_q      <= 1'b0;
         alarm_q     <= 1'b0;
         fert_pend_q <= 1'b0;
         zone_q      <= '0;
`ifndef IRRIG_FIXED_PRIORITY_EN
         rr_q        <= ZW'(NUM_ZONES - 1);
`endif
      end else begin
         state_q     <= state_d;
         alarm_q     <= (Nv == NV_EMPTY);
         mist_q      <= (state_d == MIX);
         limp_q      <= (state_d == CLEAN);
         fert_pend_q <= ((state_d == MIX) && (state_q != MIX)) ? 1'b0 : (fert_pend_q | Adub);
         if (state_d == IRRIGATE) begin
            // Zone and pump type are latched at grant; later Us/Mode changes do not disturb the run.
            if (state_q == IDLE) begin
               valve_q <= NUM_ZONES'(1) << sel;
               asp_q   <= Mode[sel];
               got_q   <= ~Mode[sel];
               zone_q  <= sel;
`ifndef IRRIG_FIXED_PRIORITY_EN
               rr_q    <= sel;
`endif
            end
         end else begin
            valve_q <= '0;
            asp_q   <= 1'b0;
            got_q   <= 1'b0;
         end
      end
   end

   assign Valve    = valve_q;
   assign Asp      = asp_q;
   assign Got      = got_q;
   assign Mist     = mist_q;
   assign Limp     = limp_q;
   assign Alarm    = alarm_q;
   assign Zone_idx = zone_q;
   assign Time_bcd = bcd;

endmodule

// File: tb/tb_irrig_zone_ctrl.sv
// Directed bench for irrig_zone_ctrl with TICK_DIV=4 and short run times.
// Latency: n/a.
// Backpressure: n/a.
module tb_irrig_zone_ctrl;

   logic       Clk;
   logic       Rst;
   logic [3:0] Us, Mode;
   logic [1:0] Nv;
   logic       Adub;
   logic [3:0] Valve;
   logic       Asp, Got, Mist, Limp, Alarm;
   logic [1:0] Zone_idx;
   logic [7:0] Time_bcd;

   int n_chk = 0;
   int n_err = 0;

   irrig_zone_ctrl #(
      .NUM_ZONES(4), .TICK_DIV(4), .SPRINKLE_TIME(15),
      .DRIP_TIME(12), .MIX_TIME(2), .CLEAN_TIME(3)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Us(Us), .Mode(Mode), .Nv(Nv), .Adub(Adub),
      .Valve(Valve), .Asp(Asp), .Got(Got), .Mist(Mist), .Limp(Limp),
      .Zone_idx(Zone_idx), .Time_bcd(Time_bcd), .Alarm(Alarm)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   function automatic logic [7:0] bcd8(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [3:0] oh(input int z);
      logic [3:0] v;
      v = 4'b0001;
      return v << z;
   endfunction

   task automatic wait_on(output int cnt);
      cnt = 0;
      while (Valve == 4'b0 && cnt < 200) begin
         step(1);
         cnt++;
      end
      chk("valve_on_timeout", 32'(Valve != 4'b0), 32'd1);
   endtask

   task automatic wait_off(output int cnt);
      cnt = 0;
      while (Valve != 4'b0 && cnt < 200) begin
         step(1);
         cnt++;
      end
      chk("valve_off_timeout", 32'(Valve == 4'b0), 32'd1);
   endtask

   int exp_z[4];
   int gap, len, cnt, bad;
   int z_after_clean;

   initial begin
`ifdef IRRIG_FIXED_PRIORITY_EN
      exp_z = '{0, 0, 0, 0};
      z_after_clean = 0;
`else
      exp_z = '{0, 1, 3, 0};
      z_after_clean = 3;
`endif
      Rst = 1'b1; Us = 4'b0; Mode = 4'b0; Nv = 2'b10; Adub = 1'b0;
      #1 Rst = 1'b0;
      #1;
      chk("rst_valve", 32'(Valve), 32'h0);
      chk("rst_time",  32'(Time_bcd), 32'h00);
      chk("rst_zone",  32'(Zone_idx), 32'h0);
      chk("rst_pumps", 32'({Asp, Got, Mist, Limp, Alarm}), 32'h0);
      step(2);
      Rst = 1'b1;
      step(1);

      // Sprinkler zone 0: 16 displayed values x 4 cycles, then exit.
      Us = 4'b0001; Mode = 4'b0001; Nv = 2'b10;
      step(1);
      chk("spr_valve", 32'(Valve), 32'h1);
      chk("spr_asp",   32'(Asp), 32'h1);
      chk("spr_got",   32'(Got), 32'h0);
      Us = 4'b0;
      for (int c = 0; c < 64; c++) begin
         chk("spr_time", 32'(Time_bcd), 32'(bcd8(15 - c / 4)));
         chk("spr_nib",  32'(Time_bcd[3:0] <= 4'd9 && Time_bcd[7:4] <= 4'd9), 32'd1);
         if (c == 24) chk("spr_10_to_09", 32'(Time_bcd), 32'h09);
         chk("spr_on", 32'(Valve), 32'h1);
         step(1);
      end
      chk("spr_off_valve", 32'(Valve), 32'h0);
      chk("spr_off_asp",   32'(Asp), 32'h0);
      chk("spr_idle_time", 32'(Time_bcd), 32'h00);
      chk("spr_idle_zone", 32'(Zone_idx), 32'h0);

      // Reset in the middle of a zone-2 run.
      Us = 4'b0100; Mode = 4'b0000;
      step(1);
      chk("pre_rst_valve", 32'(Valve), 32'h4);
      Us = 4'b0;
      step(5);
      Rst = 1'b0;
      #1;
      chk("mid_rst_valve", 32'(Valve), 32'h0);
      chk("mid_rst_got",   32'(Got), 32'h0);
      chk("mid_rst_time",  32'(Time_bcd), 32'h00);
      chk("mid_rst_zone",  32'(Zone_idx), 32'h0);
      step(1);
      Rst = 1'b1;

      // Drip zones 0,1,3 requesting; rotation across four runs.
      Us = 4'b1011; Mode = 4'b0000; Nv = 2'b10;
      for (int r = 0; r < 4; r++) begin
         wait_on(gap);
         chk("rr_gap",   32'(gap), 32'd1);
         chk("rr_valve", 32'(Valve), 32'(oh(exp_z[r])));
         chk("rr_zone",  32'(Zone_idx), 32'(exp_z[r]));
         chk("rr_pumps", 32'({Asp, Got}), 32'b01);
         chk("rr_time",  32'(Time_bcd), 32'h12);
         if (r == 3) Us = 4'b0;
         wait_off(len);
         chk("rr_len",       32'(len), 32'd52);
         chk("rr_idle_time", 32'(Time_bcd), 32'h00);
         chk("rr_idle_zone", 32'(Zone_idx), 32'(exp_z[r]));
      end

      // Low tank: sprinkler zone 0 is skipped, drip zone 1 runs.
      Nv = 2'b01; Us = 4'b0011; Mode = 4'b0001;
      wait_on(gap);
      chk("low_valve", 32'(Valve), 32'h2);
      chk("low_pumps", 32'({Asp, Got}), 32'b01);
      Us = 4'b0001;
      wait_off(len);
      chk("low_len", 32'(len), 32'd52);
      step(8);
      chk("low_skip0", 32'(Valve), 32'h0);
      chk("low_noasp", 32'(Asp), 32'h0);
      Us = 4'b0; Nv = 2'b10;
      step(1);

      // Fertilize request during a zone-2 run.
      Us = 4'b0100; Mode = 4'b0000;
      wait_on(gap);
      chk("fert_valve", 32'(Valve), 32'h4);
      Us = 4'b1111;
      step(5);
      Adub = 1'b1;
      step(1);
      Adub = 1'b0;
      wait_off(len);
      chk("fert_zone_len", 32'(len + 6), 32'd52);
      chk("fert_idle_mist", 32'(Mist), 32'h0);
      step(1);
      chk("mix_on",   32'(Mist), 32'h1);
      chk("mix_time", 32'(Time_bcd), 32'h02);
      cnt = 0;
      while (Mist && cnt < 100) begin
         cnt++;
         step(1);
      end
      chk("mix_len",    32'(cnt), 32'd12);
      chk("clean_on",   32'(Limp), 32'h1);
      chk("clean_time", 32'(Time_bcd), 32'h03);
      cnt = 0;
      bad = 0;
      while (Limp && cnt < 100) begin
         if (Valve != 4'b0 || Asp || Got || Mist) bad++;
         cnt++;
         step(1);
      end
      chk("clean_len",   32'(cnt), 32'd16);
      chk("clean_quiet", 32'(bad), 32'd0);
      wait_on(gap);
      chk("resume_gap",   32'(gap), 32'd1);
      chk("resume_valve", 32'(Valve), 32'(oh(z_after_clean)));

      // Tank empties mid-run.
      step(3);
      Nv = 2'b00;
      step(1);
      chk("empty_alarm", 32'(Alarm), 32'h1);
      chk("empty_valve", 32'(Valve), 32'h0);
      chk("empty_got",   32'(Got), 32'h0);
      chk("empty_time",  32'(Time_bcd), 32'h00);
      step(10);
      chk("empty_hold_valve", 32'(Valve), 32'h0);
      chk("empty_hold_alarm", 32'(Alarm), 32'h1);
      Nv = 2'b10;
      step(1);
      chk("refill_alarm", 32'(Alarm), 32'h0);
      chk("refill_valve", 32'(Valve), 32'h1);
      Us = 4'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/irrig_zone_ctrl.md
Name: irrig_zone_ctrl

Overview:
- Parametrised multi-zone successor to the single-zone irrigation controller.
- Schedules N zones one at a time, each as sprinkler (Asp) or drip (Got).
- Runs a fertilizer mix + line-cleaning sequence during which all irrigation is suspended.
- Drives a 2-digit BCD countdown for the display selector; sits between the sensor inputs and the display/actuator outputs in main.

Parameters:
- NUM_ZONES, 4, zone count (2..8).
- TICK_DIV, 50000000, Clk cycles per 1 s timer tick (sim: 4).
- SPRINKLE_TIME, 15, sprinkler run, s (1..99).
- DRIP_TIME, 30, drip run, s (1..99).
- MIX_TIME, 5, fertilizer mix, s (1..99).
- CLEAN_TIME, 10, line cleaning, s (1..99).

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous active-low reset.
- Us  in  NUM_ZONES  soil-dry request per zone, 1 = dry.
- Mode  in  NUM_ZONES  per-zone type, 1 = sprinkler, 0 = drip.
- Nv  in  2  tank level: 00 empty, 01 low, 1x ok.
- Adub  in  1  fertilize request, active-high level.
- Valve  out  NUM_ZONES  one-hot zone valve.
- Asp  out  1  sprinkler pump.
- Got  out  1  drip pump.
- Mist  out  1  mixer on.
- Limp  out  1  cleaning on.
- Zone_idx  out  $clog2(NUM_ZONES)  active/last zone.
- Time_bcd  out  8  remaining seconds, BCD {tens, units}.
- Alarm  out  1  tank empty.

Behaviour:
- All outputs registered.
- Reset (Rst=0, async): state IDLE; Valve, Asp, Got, Mist, Limp, Alarm = 0; Time_bcd = 8'h00; Zone_idx = 0; fert_pend = 0; prescaler = 0; RR pointer set so zone 0 is served first.
- Prescaler: counts 0..TICK_DIV-1 and pulses tick on wrap. Cleared whenever the timer loads, so the first tick arrives TICK_DIV cycles after entering a timed state.
- fert_pend: set on any cycle with Adub=1; cleared on entry to MIX.
- States:
  - IDLE:
    - fert_pend or Adub → MIX. Fertilize has priority over irrigation.
    - Otherwise, with eligible zones → IRRIGATE, with zone chosen by round-robin from the last served zone + 1.
    - Eligible zone: Us[i]=1 and Nv≠00, and, if Nv=01, Mode[i]=0 (drip only on low tank).
  - IRRIGATE:
    - Valve[z]=1; Asp=Mode[z]; Got=~Mode[z].
    - Timer loads SPRINKLE_TIME or DRIP_TIME.
    - Us falling mid-run does not abort.
    - On the tick where the timer is 00 → IDLE. Run length = (T+1)·TICK_DIV cycles: display shows T..00, then one more tick exits.
  - MIX: Mist=1; timer = MIX_TIME; on expiry → CLEAN.
  - CLEAN: Limp=1; timer = CLEAN_TIME. Valve, Asp and Got are forced 0. On expiry → IDLE.
- Latency: request seen in IDLE → Valve/pump asserted on the next Clk edge.
- Adub arriving during IRRIGATE: the zone completes, then IDLE → MIX (one IDLE cycle).
- Tank empty (Nv=00):
  - Alarm=1 the following cycle, held while Nv=00.
  - IRRIGATE aborts to IDLE next cycle and outputs drop. The RR pointer still advances past the aborted zone.
  - MIX and CLEAN continue; they do not draw on the tank.
- BCD countdown: units 0 → units 9, tens−1; 10 → 09, 01 → 00. Never yields a non-BCD nibble. At 00 the timer holds.
- Time_bcd = 00 in IDLE.
- Zone_idx holds the last served zone in IDLE.
- Elaboration error if any time parameter is 0 or >99, or NUM_ZONES is outside 2..8.

Optional Feature:
- IRRIG_FIXED_PRIORITY_EN defined: zone selection is fixed priority, lowest eligible index wins, and the RR pointer is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Package irrig_pkg: state enum (IDLE, IRRIGATE, MIX, CLEAN); level constants (NV_EMPTY=2'b00, NV_LOW=2'b01); MODE_SPRINKLE=1'b1, MODE_DRIP=1'b0; BCD helper function to_bcd for parameter loads.
- Sub-module bcd_down_timer: load, load value, tick in; 8-bit BCD out and zero flag; owns the prescaler.
- FSM and zone arbiter stay in irrig_zone_ctrl.

Test Plan (TICK_DIV=4, NUM_ZONES=4, SPRINKLE_TIME=15, DRIP_TIME=12, MIX_TIME=2, CLEAN_TIME=3):
- Reset mid-IRRIGATE (Rst low for 1 cycle) → all outputs 0 and Time_bcd=00 immediately; next request serves zone 0.
- Us=4'b0001, Mode=4'b0001, Nv=2'b10 → Valve=0001 and Asp=1 next cycle. Time_bcd steps 15, 14, …, 10, 09, …, 00, with 10→09 verified and no 1A/0F values. Outputs drop after 64 cycles.
- Us=4'b1011 held, Mode=0, Nv=2'b10 → zones served 0, 1, 3, 0 with Got=1. Under IRRIG_FIXED_PRIORITY_EN, zone 0 every time.
- Nv=2'b01, Us=4'b0011, Mode=4'b0001 → only zone 1 (drip) runs; zone 0 is skipped.
- Adub pulse 1 cycle during zone-2 run → zone 2 completes, 1 IDLE cycle, then Mist=1 for 12 cycles, then Limp=1 for 16 cycles with Valve=0, Asp=0, Got=0 despite Us=1111. Then irrigation resumes at zone 3.
- Nv→00 during IRRIGATE → Alarm=1 and Valve=0 next cycle. No new zone starts until Nv≠00.
